// File: rtl/alu.sv
// Registered WIDTH-bit ALU: one ADD/SUB/AND/OR/XOR per clock, result is
// WIDTH+1 bits wide (top bit = carry for ADD, borrow for SUB, 0 otherwise).
// Valid qualification: in_valid marks a, b and op as meaningful at a rising
// edge; out_valid is its registered copy one edge later. There is no ready:
// the unit accepts a new operation on every cycle. When in_valid is low,
// result, zero and op_err keep their last values and only out_valid drops.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH:0]   result,
    output logic             out_valid,
    output logic             zero,
    output logic             op_err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] next_result;
    logic           next_err;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    // Next result and opcode legality; SUB wraps mod 2^(WIDTH+1) so the top bit is the borrow.
    always_comb begin
        next_result = '0;
        next_err    = 1'b0;
        unique case (op)
            OP_ADD:  next_result = a_ext + b_ext;
            OP_SUB:  next_result = a_ext - b_ext;
            OP_AND:  next_result = a_ext & b_ext;
            OP_OR:   next_result = a_ext | b_ext;
            OP_XOR:  next_result = a_ext ^ b_ext;
            default: begin
                next_result = '0;
                next_err    = 1'b1;
            end
        endcase
    end

    // Output registers: reset wins, valid ops update everything, idle cycles hold data.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= next_result;
                op_err <= next_err;
                zero   <= !next_err && (next_result == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan vectors, streaming, mid-stream
// reset and a randomized run against an integer-arithmetic reference model.
module tb_alu;

    localparam int WIDTH = 4;
    localparam int W     = WIDTH + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [W-1:0]     result;
    logic             out_valid;
    logic             zero;
    logic             op_err;

    int tests;
    int fails;

    // Expected output state as the specification describes it
    int m_result;
    int m_valid;
    int m_zero;
    int m_err;

    // Scoreboard of results still owed by the DUT
    logic [W-1:0] exp_q[$];

    alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (result),
        .out_valid(out_valid),
        .zero     (zero),
        .op_err   (op_err)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the opcode table
    function automatic void ref_op(input int o, input int x, input int y,
                                   output int r, output int err);
        int modv;
        modv = 1 << W;
        err  = 0;
        case (o)
            0: r = x + y;
            1: r = ((x - y) % modv + modv) % modv;
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            default: begin r = 0; err = 1; end
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_valid"}, int'(out_valid), m_valid);
        check({tag, "_result"}, int'(result), m_result);
        check({tag, "_zero"}, int'(zero), m_zero);
        check({tag, "_err"}, int'(op_err), m_err);
    endtask

    // Driver: apply one cycle of inputs, confirm outputs do not move before
    // the edge, then check the post-edge state and the scoreboard.
    task automatic step(input logic r, input logic v, input int aa, input int bb,
                        input int oo, input string tag);
        int res;
        int err;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = aa[WIDTH-1:0];
        b        = bb[WIDTH-1:0];
        op       = oo[2:0];
        #1;
        check({tag, "_pre_result"}, int'(result), m_result);
        check({tag, "_pre_valid"}, int'(out_valid), m_valid);

        ref_op(oo, aa, bb, res, err);
        if (r) begin
            m_result = 0; m_valid = 0; m_zero = 0; m_err = 0;
            exp_q.delete();
        end else if (v) begin
            m_result = res;
            m_valid  = 1;
            m_err    = err;
            m_zero   = (err == 0 && res == 0) ? 1 : 0;
            exp_q.push_back(res[W-1:0]);
        end else begin
            m_valid = 0;
        end

        @(posedge clk);
        #1;
        check_outputs(tag);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_unexpected"}, 1, 0);
            end else begin
                check({tag, "_sb"}, int'(result), int'(exp_q.pop_front()));
            end
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        m_result = 0; m_valid = 0; m_zero = 0; m_err = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;

        // Reset held two cycles with busy inputs
        step(1, 1, 15, 15, 0, "rst0");
        step(1, 1, 15, 15, 0, "rst1");
        check("rst_result_const", int'(result), 0);
        check("rst_valid_const", int'(out_valid), 0);

        // Arithmetic
        step(0, 1, 3, 1, 0, "add_3_1");      check("add_3_1_c", int'(result), 5'b00100);
        step(0, 1, 15, 15, 0, "add_15_15");  check("add_15_15_c", int'(result), 5'b11110);
        step(0, 1, 6, 3, 1, "sub_6_3");      check("sub_6_3_c", int'(result), 5'b00011);
        step(0, 1, 1, 3, 1, "sub_1_3");      check("sub_1_3_c", int'(result), 5'b11110);
        step(0, 1, 5, 5, 1, "sub_5_5");      check("sub_5_5_z", int'(zero), 1);

        // Logic
        step(0, 1, 4'b1100, 4'b1010, 2, "and"); check("and_c", int'(result), 5'b01000);
        step(0, 1, 4'b1100, 4'b1010, 3, "or");  check("or_c", int'(result), 5'b01110);
        step(0, 1, 4'b1100, 4'b1010, 4, "xor"); check("xor_c", int'(result), 5'b00110);
        step(0, 1, 4'b1010, 4'b1010, 4, "xor_eq"); check("xor_eq_z", int'(zero), 1);

        // Unsupported opcodes
        for (int o = 5; o <= 7; o++) begin
            step(0, 1, 15, 15, o, $sformatf("bad%0d", o));
            check($sformatf("bad%0d_err_c", o), int'(op_err), 1);
        end

        // Valid gating: result holds while out_valid drops
        step(0, 1, 3, 1, 0, "gate_add");
        step(0, 0, 9, 1, 0, "gate_idle");
        check("gate_hold_c", int'(result), 5'b00100);

        // Five back-to-back ops
        step(0, 1, 7, 8, 0, "s0");
        step(0, 1, 2, 9, 1, "s1");
        step(0, 1, 12, 6, 2, "s2");
        step(0, 1, 5, 10, 3, "s3");
        step(0, 1, 9, 9, 4, "s4");

        // Mid-stream reset pulse, then normal operation
        step(0, 1, 4, 4, 0, "m0");
        step(1, 1, 15, 1, 0, "m_rst");
        check("m_rst_result_c", int'(result), 0);
        step(0, 1, 10, 3, 1, "m_after"); check("m_after_c", int'(result), 7);

        // Randomized run against the reference model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 7), $sformatf("rnd%0d", i));
        end

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
